// File: rtl/object_buffer_fifo_pkg.sv
// Shared types for the object buffer: the table record produced by fetch,
// the buffer slot wrapper (valid bit + record) and the default depth.
package object_buffer_fifo_pkg;

    localparam int FIELD_ID_W       = 8;
    localparam int OB_DEFAULT_DEPTH = 64;

    typedef struct packed {
        logic [FIELD_ID_W-1:0] field_id;
        logic [3:0]            field_type;
        logic [15:0]           offset;
    } TABLE_ENTRY;

    typedef struct packed {
        logic       valid;
        TABLE_ENTRY entry;
    } OB_SLOT;

endpackage

// File: rtl/object_buffer_fifo_field_search.sv
// Combinational oldest-first field-ID match over all buffer slots.
// Slots are rotated so that offset 0 is the read pointer; the smallest
// matching offset wins and is converted back to a physical slot index.
module ob_field_search
    import object_buffer_fifo_pkg::*;
#(
    parameter  int DEPTH = OB_DEFAULT_DEPTH,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  OB_SLOT                slots [DEPTH],
    input  logic [IDX_W-1:0]      rd_ptr,
    input  logic [FIELD_ID_W-1:0] id,
    output logic                  hit,
    output logic [IDX_W-1:0]      idx
);

    logic [DEPTH-1:0] match;
    logic [DEPTH-1:0] rot_match;
    logic [IDX_W-1:0] offset;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match[gi] = slots[gi].valid && (slots[gi].entry.field_id == id);
        end
        // rot_match[k] is the slot k positions past the read pointer (wraps mod DEPTH)
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rot
            assign rot_match[gi] = match[rd_ptr + IDX_W'(gi)];
        end
    endgenerate

    // Priority encode: lowest rotated offset (oldest entry) wins
    always_comb begin
        offset = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (rot_match[k]) offset = IDX_W'(k);
        end
        hit = |rot_match;
        idx = hit ? (rd_ptr + offset) : '0;
    end

endmodule

// File: rtl/object_buffer_fifo.sv
// Circular FIFO of TABLE_ENTRY records between fetch and encode, with a
// show-ahead ready/valid drain port, almost-full warning, single-cycle
// flush and a registered field-ID lookup over the occupied slots.
module object_buffer_fifo
    import object_buffer_fifo_pkg::*;
#(
    parameter  int DEPTH        = OB_DEFAULT_DEPTH,
    parameter  int AFULL_THRESH = DEPTH - 4,
    localparam int IDX_W        = $clog2(DEPTH),
    localparam int CNT_W        = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  TABLE_ENTRY            new_entry,
    input  logic                  valid_in,
    output logic                  full,
    output logic                  almost_full,
    output TABLE_ENTRY            out_entry,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [CNT_W-1:0]      count,
    input  logic                  lookup_en,
    input  logic [FIELD_ID_W-1:0] lookup_id,
    output logic                  lookup_valid,
    output logic                  lookup_hit,
    output logic [IDX_W-1:0]      lookup_idx,
    output TABLE_ENTRY            lookup_entry
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);

    OB_SLOT           entries [DEPTH];
    logic [IDX_W-1:0] wr_ptr_reg;
    logic [IDX_W-1:0] curr;          // read pointer; name kept for debug printers
    logic [CNT_W-1:0] count_reg;

    logic             lookup_valid_reg;
    logic             lookup_hit_reg;
    logic [IDX_W-1:0] lookup_idx_reg;
    TABLE_ENTRY       lookup_entry_reg;

    logic             push_acc;
    logic             pop_acc;
    logic             search_hit;
    logic [IDX_W-1:0] search_idx;

    assign full        = (count_reg == DEPTH_C);
    assign almost_full = (count_reg >= AFULL_C);
    assign out_valid   = (count_reg != '0);
    assign count       = count_reg;
    // Gate the show-ahead record so an empty buffer never exposes stale storage
    assign out_entry   = out_valid ? entries[curr].entry : '0;

    assign push_acc = valid_in && !full;
    assign pop_acc  = out_valid && out_ready;

    assign lookup_valid = lookup_valid_reg;
    assign lookup_hit   = lookup_hit_reg;
    assign lookup_idx   = lookup_idx_reg;
    assign lookup_entry = lookup_entry_reg;

    ob_field_search #(
        .DEPTH (DEPTH)
    ) u_search (
        .slots  (entries),
        .rd_ptr (curr),
        .id     (lookup_id),
        .hit    (search_hit),
        .idx    (search_idx)
    );

    // Storage, pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            curr       <= '0;
            count_reg  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            if (push_acc) begin
                entries[wr_ptr_reg].entry <= new_entry;
                entries[wr_ptr_reg].valid <= 1'b1;
                wr_ptr_reg                <= wr_ptr_reg + 1'b1;
            end
            if (pop_acc) begin
                entries[curr].valid <= 1'b0;
                curr                <= curr + 1'b1;
            end
            count_reg <= count_reg + CNT_W'(push_acc) - CNT_W'(pop_acc);
        end
    end

    // Lookup result register; searches pre-edge contents, so flush does not affect it
    always_ff @(posedge clk) begin
        if (reset) begin
            lookup_valid_reg <= 1'b0;
            lookup_hit_reg   <= 1'b0;
            lookup_idx_reg   <= '0;
            lookup_entry_reg <= '0;
        end else begin
            lookup_valid_reg <= lookup_en;
            if (lookup_en) begin
                lookup_hit_reg   <= search_hit;
                lookup_idx_reg   <= search_idx;
                lookup_entry_reg <= search_hit ? entries[search_idx].entry : '0;
            end
        end
    end

endmodule
